// File: rtl/load_store_unit.sv
// Three-state load/store sequencer between a core request/response port and a
// byte-addressed memory; checks alignment, range and funct3 before any access.
module load_store_unit #(
  parameter logic [31:0] START_ADDRESS = 32'd0,
  parameter logic [31:0] STOP_ADDRESS  = 32'd1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] wr_addr,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic [1:0]  wr_mode,
  output logic [31:0] rd_addr,
  output logic        rd_en,
  output logic [1:0]  rd_mode,
  input  logic [31:0] rd_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_err;
  logic        funct3_ok;
  logic        misaligned;
  logic [2:0]  req_size;
  logic [32:0] req_last;
  logic [31:0] load_ext;
  logic [1:0]  mode;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
    if (req_we) funct3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010};
    else        funct3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misaligned = ((req_size == 3'd2) && req_addr[0]) ||
                 ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
    // 33-bit end address so a request near 2^32 cannot wrap back into range
    req_last   = {1'b0, req_addr} + {30'd0, req_size} - 33'd1;
    req_err    = !funct3_ok || misaligned || (req_addr < START_ADDRESS) ||
                 (req_last > {1'b0, STOP_ADDRESS});
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{rd_data[7]}}, rd_data[7:0]};
      3'b100:  load_ext = {24'd0, rd_data[7:0]};
      3'b001:  load_ext = {{16{rd_data[15]}}, rd_data[15:0]};
      3'b101:  load_ext = {16'd0, rd_data[15:0]};
      default: load_ext = rd_data;
    endcase
    case (funct3_q[1:0])
      2'b00:   mode = 2'b00;
      2'b01:   mode = 2'b01;
      default: mode = 2'b11;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = req_err ? RESP : ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= req_err;
        rdata_q  <= 32'd0;
      end
      if (state == ACCESS && !we_q) rdata_q <= load_ext;
    end
  end

  // Strobes come from the state register only, never from core inputs.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  assign wr_en      = (state == ACCESS) && we_q;
  assign rd_en      = (state == ACCESS) && !we_q;
  assign wr_addr    = addr_q;
  assign wr_data    = wdata_q;
  assign wr_mode    = mode;
  assign rd_addr    = addr_q;
  assign rd_mode    = mode;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory model plus a rule-based
// reference that predicts error, data and latency of every request.
module tb_load_store_unit;
  localparam longint START = 0;
  localparam longint STOP  = 1023;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
  logic        wr_en, rd_en;
  logic [1:0]  wr_mode, rd_mode;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  logic [7:0] mem     [0:1023];
  logic [7:0] ref_mem [0:1023];

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data), .wr_mode(wr_mode),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_mode(rd_mode), .rd_data(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Memory commits whatever strobe it sees at the edge, reset or not.
  always @(posedge clk) begin
    if (wr_en === 1'b1) begin
      for (int i = 0; i < 4; i++)
        if (i == 0 || (i == 1 && wr_mode != 2'b00) || wr_mode == 2'b11)
          mem[(wr_addr + i) % 1024] <= wr_data[8*i +: 8];
    end
  end

  always_comb begin
    rd_data = 32'd0;
    for (int i = 0; i < 4; i++)
      if (i == 0 || (i == 1 && rd_mode != 2'b00) || rd_mode == 2'b11)
        rd_data[8*i +: 8] = mem[(rd_addr + i) % 1024];
  end

  // Reference: predicts the outcome from the architectural rules and applies
  // successful stores to ref_mem.
  task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wdata, output bit err, output bit [31:0] rdata);
    int size;
    bit [31:0] raw;
    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    err  = we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (addr % size != 0) err = 1'b1;
    if (longint'(addr) < START || longint'(addr) + size - 1 > STOP) err = 1'b1;
    rdata = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];
      end else begin
        raw = 32'd0;
        for (int i = 0; i < size; i++) raw[8*i +: 8] = ref_mem[addr + i];
        if (f3 == 3'd0 && raw >= 32'h80)       rdata = raw - 32'h100;
        else if (f3 == 3'd1 && raw >= 32'h8000) rdata = raw - 32'h10000;
        else                                    rdata = raw;
      end
    end
  endtask

  task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wdata, input int hold,
                        output bit [31:0] got_rdata, output bit got_err, output int acc_cycle);
    bit exp_err, seen;
    bit [31:0] exp_rdata;
    bit [1:0] exp_mode;
    int k, wr_cnt, rd_cnt, exp_lat;
    model(we, f3, addr, wdata, exp_err, exp_rdata);
    exp_mode = (f3 == 3'd0 || f3 == 3'd4) ? 2'b00 : (f3 == 3'd1 || f3 == 3'd5) ? 2'b01 : 2'b11;
    exp_lat  = exp_err ? 1 : 2;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    resp_ready = (hold == 0);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL req_ready_idle got %b want 1", req_ready);
    end
    @(posedge clk); acc_cycle = cycle; #1;
    // A different store held on the request port while busy must be ignored.
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h3C0; req_wdata = $urandom;
    k = 1; seen = 0; wr_cnt = 0; rd_cnt = 0;
    while (!seen && k <= 8) begin
      if (wr_en === 1'b1) begin
        wr_cnt++; vectors++;
        if ({wr_addr, wr_data, wr_mode} !== {addr, wdata, exp_mode}) begin
          miscompares++;
          $display("FAIL wr_port got %h/%h/%b want %h/%h/%b", wr_addr, wr_data, wr_mode, addr, wdata, exp_mode);
        end
      end
      if (rd_en === 1'b1) begin
        rd_cnt++; vectors++;
        if ({rd_addr, rd_mode} !== {addr, exp_mode}) begin
          miscompares++; $display("FAIL rd_port got %h/%b want %h/%b", rd_addr, rd_mode, addr, exp_mode);
        end
      end
      if (resp_valid === 1'b1) seen = 1'b1;
      else begin @(posedge clk); #1; k++; end
    end
    req_valid = 1'b0;
    got_rdata = resp_rdata; got_err = resp_err;
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL resp_timeout no resp_valid within 8 cycles");
    end else if (k != exp_lat) begin
      miscompares++; $display("FAIL latency got %0d want %0d", k, exp_lat);
    end
    vectors++;
    if (resp_err !== exp_err || resp_rdata !== exp_rdata) begin
      miscompares++;
      $display("FAIL resp_data got err=%b rdata=%h want err=%b rdata=%h", resp_err, resp_rdata, exp_err, exp_rdata);
    end
    vectors++;
    if (wr_cnt != int'(we && !exp_err) || rd_cnt != int'(!we && !exp_err)) begin
      miscompares++;
      $display("FAIL strobes got wr=%0d rd=%0d want wr=%0d rd=%0d", wr_cnt, rd_cnt, we && !exp_err, !we && !exp_err);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      vectors++;
      if ({resp_valid, req_ready, resp_err, resp_rdata, wr_en, rd_en} !==
          {1'b1, 1'b0, exp_err, exp_rdata, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL resp_hold got v=%b rdy=%b err=%b rdata=%h wr=%b rd=%b", resp_valid, req_ready, resp_err, resp_rdata, wr_en, rd_en);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL back_to_idle got rdy=%b v=%b want 1/0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    vectors++;
    if ({req_ready, resp_valid, resp_err, wr_en, rd_en} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_ctrl got rdy=%b v=%b err=%b wr=%b rd=%b", req_ready, resp_valid, resp_err, wr_en, rd_en);
    end
    vectors++;
    if ({resp_rdata, wr_addr, wr_data, wr_mode, rd_addr, rd_mode} !== 132'd0) begin
      miscompares++;
      $display("FAIL reset_data got %h %h %h %b %h %b", resp_rdata, wr_addr, wr_data, wr_mode, rd_addr, rd_mode);
    end
  endtask

  task automatic test_directed();
    bit [31:0] r; bit e; int c;
    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, r, e, c);
    do_req(0, 3'b010, 32'h10, 32'h0, 0, r, e, c);
    vectors++;
    if (r !== 32'hDEADBEEF || e !== 1'b0) begin
      miscompares++; $display("FAIL sw_lw got %h err=%b want deadbeef err=0", r, e);
    end
    do_req(1, 3'b000, 32'h21, 32'h000000F0, 0, r, e, c);
    do_req(0, 3'b000, 32'h21, 32'h0, 0, r, e, c);
    vectors++;
    if (r !== 32'hFFFFFFF0) begin
      miscompares++; $display("FAIL lb_sign got %h want fffffff0", r);
    end
    do_req(0, 3'b100, 32'h21, 32'h0, 0, r, e, c);
    vectors++;
    if (r !== 32'h000000F0) begin
      miscompares++; $display("FAIL lbu_zero got %h want 000000f0", r);
    end
    do_req(0, 3'b001, 32'h13, 32'h0, 0, r, e, c);
    vectors++;
    if (e !== 1'b1 || r !== 32'd0) begin
      miscompares++; $display("FAIL lh_misaligned got err=%b rdata=%h want 1/0", e, r);
    end
  endtask

  task automatic test_errors();
    bit [31:0] r; bit e; int c;
    do_req(0, 3'b010, 32'h3FE, 32'h0, 0, r, e, c);
    vectors++;
    if (e !== 1'b1) begin miscompares++; $display("FAIL lw_range got err=%b want 1", e); end
    do_req(0, 3'b011, 32'h20, 32'h0, 0, r, e, c);
    vectors++;
    if (e !== 1'b1) begin miscompares++; $display("FAIL load_f3_011 got err=%b want 1", e); end
    do_req(1, 3'b100, 32'h20, 32'h12345678, 0, r, e, c);
    vectors++;
    if (e !== 1'b1) begin miscompares++; $display("FAIL store_f3_100 got err=%b want 1", e); end
    do_req(0, 3'b010, 32'h3FC, 32'h0, 0, r, e, c);
    do_req(0, 3'b100, 32'h3FF, 32'h0, 0, r, e, c);
    do_req(0, 3'b010, 32'hFFFF_FFFC, 32'h0, 0, r, e, c);
  endtask

  task automatic test_backpressure();
    bit [31:0] r; bit e; int c;
    do_req(1, 3'b001, 32'h40, 32'h0000_8123, 0, r, e, c);
    do_req(0, 3'b001, 32'h40, 32'h0, 5, r, e, c);
    do_req(0, 3'b101, 32'h40, 32'h0, 3, r, e, c);
  endtask

  task automatic test_back_to_back();
    bit [31:0] r; bit e; int c0, c1;
    do_req(1, 3'b010, 32'h50, $urandom, 0, r, e, c0);
    for (int i = 0; i < 4; i++) begin
      do_req(i[0], 3'b010, 32'h50 + 32'(4 * i), $urandom, 0, r, e, c1);
      vectors++;
      if (c1 - c0 != 3) begin
        miscompares++; $display("FAIL throughput got %0d cycles want 3", c1 - c0);
      end
      c0 = c1;
    end
  endtask

  task automatic test_random();
    bit [31:0] r, addr; bit e; int c;
    bit [2:0] f3;
    bit [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int n = 0; n < 40; n++) begin
      addr = ($urandom_range(0, 3) == 0) ? $urandom_range(1012, 1030) : $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) addr = addr & ~32'd3;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
      do_req(1'($urandom_range(0, 1)), f3, addr, $urandom, $urandom_range(0, 2), r, e, c);
    end
  endtask

  task automatic test_reset_cases();
    bit [31:0] r, exp_r; bit e, exp_e; int c;
    // Reset in the accept cycle discards the store.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h80; req_wdata = 32'hCAFE_F00D;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    vectors++;
    if (wr_en !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_accept got wr=%b rdy=%b want 0/1", wr_en, req_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (wr_en !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_accept_after got wr=%b v=%b want 0/0", wr_en, resp_valid);
    end
    do_req(0, 3'b010, 32'h80, 32'h0, 0, r, e, c);
    // Reset in ACCESS: the store still commits but no response follows.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h84; req_wdata = 32'h1357_9BDF;
    model(1, 3'b010, 32'h84, 32'h1357_9BDF, exp_e, exp_r);
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_access got v=%b rdy=%b want 0/1", resp_valid, req_ready);
    end
    do_req(0, 3'b010, 32'h84, 32'h0, 0, r, e, c);
    // Reset in RESP drops the pending response.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h84; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; resp_ready = 1'b1;
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_resp got v=%b rdy=%b rdata=%h want 0/1/0", resp_valid, req_ready, resp_rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_cases();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
